// File: rtl/sprite_pkg.sv
// Shared constants for the sprite layer engine: config opcodes,
// attribute bit positions and a constant-evaluable log2 helper.
package sprite_pkg;

   localparam logic [1:0] OP_POS  = 2'b00;
   localparam logic [1:0] OP_ATTR = 2'b01;
   localparam logic [1:0] OP_PIX  = 2'b10;

   localparam int ATTR_VIS   = 0;
   localparam int ATTR_HFLIP = 1;
   localparam int ATTR_VFLIP = 2;
   localparam int ATTR_CLR   = 3;

   // Number of bits needed to index n entries (n >= 2).
   function automatic int log2w(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sprite_pattern_ram.sv
// Sprite pattern store: write port driven by the config bus, registered
// read port addressed by the hit test. A same-cycle read and write to one
// address returns the old contents.
module sprite_pattern_ram #(
   parameter int PIX_W = 8,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [PIX_W-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [PIX_W-1:0] rdata_o
);

   logic [PIX_W-1:0] mem_q [DEPTH];
   logic [PIX_W-1:0] rdata_q;

   // Write from config and registered read; contents are never reset.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_layer_engine.sv
// One chained sprite stage: holds position/attributes/pattern for a single
// sprite, composites its opaque pixels over the upstream colour two cycles
// later and flags overlaps with upstream sprites as collisions.
module sprite_layer_engine
   import sprite_pkg::*;
#(
   parameter int               COORD_W = 8,
   parameter int               PIX_W   = 8,
   parameter int               SPR_W   = 8,
   parameter int               SPR_H   = 8,
   parameter int               ID_W    = 6,
   parameter logic [PIX_W-1:0] TRANSP  = '0,
   localparam int              AW      = log2w(SPR_W * SPR_H)
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic [ID_W-1:0]      sprite_id_in,
   output logic [ID_W-1:0]      sprite_id_out,
   input  logic                 cfg_valid,
   input  logic [ID_W-1:0]      cfg_id,
   input  logic [1:0]           cfg_op,
   input  logic [AW-1:0]        cfg_addr,
   input  logic [2*COORD_W-1:0] cfg_data,
   output logic                 cfg_valid_out,
   output logic [ID_W-1:0]      cfg_id_out,
   output logic [1:0]           cfg_op_out,
   output logic [AW-1:0]        cfg_addr_out,
   output logic [2*COORD_W-1:0] cfg_data_out,
   input  logic                 pix_valid_in,
   input  logic [COORD_W-1:0]   screen_x_in,
   input  logic [COORD_W-1:0]   screen_y_in,
   input  logic [PIX_W-1:0]     rgb_in,
   input  logic                 hit_in,
   input  logic                 coll_in,
   output logic                 pix_valid_out,
   output logic [COORD_W-1:0]   screen_x_out,
   output logic [COORD_W-1:0]   screen_y_out,
   output logic [PIX_W-1:0]     rgb_out,
   output logic                 hit_out,
   output logic                 coll_out,
   output logic                 coll_status
);

   localparam int XW = log2w(SPR_W);
   localparam int YW = log2w(SPR_H);

   logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
   logic               vis_q, vis_d, hflip_q, hflip_d, vflip_q, vflip_d;
   logic               coll_q, coll_d;

   logic               vld_p1_q, hit_p1_q, coll_p1_q, inb_p1_q;
   logic [COORD_W-1:0] sx_p1_q, sy_p1_q;
   logic [PIX_W-1:0]   rgb_p1_q;
   logic               vld_p2_q, hit_p2_q, coll_p2_q;
   logic [COORD_W-1:0] sx_p2_q, sy_p2_q;
   logic [PIX_W-1:0]   rgb_p2_q;

   logic               cfg_acc, inb, opq;
   logic [COORD_W:0]   sx_e, sy_e, x_e, y_e;
   logic [XW-1:0]      rx, rx_f;
   logic [YW-1:0]      ry, ry_f;
   logic [AW-1:0]      raddr;
   logic [PIX_W-1:0]   ram_rdata;

   assign sprite_id_out = sprite_id_in + ID_W'(1);
   assign cfg_valid_out = cfg_valid;
   assign cfg_id_out    = cfg_id;
   assign cfg_op_out    = cfg_op;
   assign cfg_addr_out  = cfg_addr;
   assign cfg_data_out  = cfg_data;

   // A write in the same cycle as clear is dropped.
   assign cfg_acc = cfg_valid && (cfg_id == sprite_id_in) && !clear;

   // ---- stage 1 inputs: hit test and pattern address ----
   // One extra bit so a sprite near the right/bottom edge clips instead of wrapping.
   assign sx_e = {1'b0, screen_x_in};
   assign sy_e = {1'b0, screen_y_in};
   assign x_e  = {1'b0, x_q};
   assign y_e  = {1'b0, y_q};

   assign inb = vis_q && pix_valid_in
             && (sx_e >= x_e) && (sx_e < x_e + (COORD_W+1)'(SPR_W))
             && (sy_e >= y_e) && (sy_e < y_e + (COORD_W+1)'(SPR_H));

   // Offsets only matter modulo the sprite size, so low bits suffice;
   // with power-of-two sizes, SIZE-1-r is the bitwise complement.
   assign rx    = screen_x_in[XW-1:0] - x_q[XW-1:0];
   assign ry    = screen_y_in[YW-1:0] - y_q[YW-1:0];
   assign rx_f  = hflip_q ? ~rx : rx;
   assign ry_f  = vflip_q ? ~ry : ry;
   assign raddr = {ry_f, rx_f};

   sprite_pattern_ram #(
      .PIX_W (PIX_W),
      .DEPTH (SPR_W * SPR_H),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .we_i    (cfg_acc && (cfg_op == OP_PIX)),
      .waddr_i (cfg_addr),
      .wdata_i (cfg_data[PIX_W-1:0]),
      .raddr_i (raddr),
      .rdata_o (ram_rdata)
   );

   // ---- stage 2 inputs: composite over upstream colour ----
   assign opq = inb_p1_q && (ram_rdata != TRANSP);

   // Next sprite state: config writes plus sticky collision; a clear-collision write beats a same-cycle set.
   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      vis_d   = vis_q;
      hflip_d = hflip_q;
      vflip_d = vflip_q;
      coll_d  = coll_q;
      if (opq && hit_p1_q) coll_d = 1'b1;
      if (cfg_acc) begin
         case (cfg_op)
            OP_POS: begin
               x_d = cfg_data[COORD_W-1:0];
               y_d = cfg_data[2*COORD_W-1:COORD_W];
            end
            OP_ATTR: begin
               vis_d   = cfg_data[ATTR_VIS];
               hflip_d = cfg_data[ATTR_HFLIP];
               vflip_d = cfg_data[ATTR_VFLIP];
               if (cfg_data[ATTR_CLR]) coll_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Sprite state register.
   always_ff @(posedge clk) begin
      if (clear) begin
         x_q     <= '0;
         y_q     <= '0;
         vis_q   <= 1'b0;
         hflip_q <= 1'b0;
         vflip_q <= 1'b0;
         coll_q  <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         vis_q   <= vis_d;
         hflip_q <= hflip_d;
         vflip_q <= vflip_d;
         coll_q  <= coll_d;
      end
   end

   // Two-stage pixel pipeline; clear flushes everything so outputs read zero.
   always_ff @(posedge clk) begin
      if (clear) begin
         vld_p1_q  <= 1'b0;
         sx_p1_q   <= '0;
         sy_p1_q   <= '0;
         rgb_p1_q  <= '0;
         hit_p1_q  <= 1'b0;
         coll_p1_q <= 1'b0;
         inb_p1_q  <= 1'b0;
         vld_p2_q  <= 1'b0;
         sx_p2_q   <= '0;
         sy_p2_q   <= '0;
         rgb_p2_q  <= '0;
         hit_p2_q  <= 1'b0;
         coll_p2_q <= 1'b0;
      end else begin
         // ---- stage 1 ----
         vld_p1_q  <= pix_valid_in;
         sx_p1_q   <= screen_x_in;
         sy_p1_q   <= screen_y_in;
         rgb_p1_q  <= rgb_in;
         hit_p1_q  <= hit_in;
         coll_p1_q <= coll_in;
         inb_p1_q  <= inb;
         // ---- stage 2 ----
         vld_p2_q  <= vld_p1_q;
         sx_p2_q   <= sx_p1_q;
         sy_p2_q   <= sy_p1_q;
         rgb_p2_q  <= opq ? ram_rdata : rgb_p1_q;
         hit_p2_q  <= hit_p1_q | opq;
         coll_p2_q <= coll_p1_q | (opq && hit_p1_q);
      end
   end

   assign pix_valid_out = vld_p2_q;
   assign screen_x_out  = sx_p2_q;
   assign screen_y_out  = sy_p2_q;
   assign rgb_out       = rgb_p2_q;
   assign hit_out       = hit_p2_q;
   assign coll_out      = coll_p2_q;
   assign coll_status   = coll_q;

endmodule

// File: tb/tb_sprite_layer_engine.sv
// Bench for sprite_layer_engine: vector table, directed multi-cycle
// sequences and a randomized run against a behavioural sprite model.
module tb_sprite_layer_engine;
   localparam int COORD_W = 8;
   localparam int PIX_W   = 8;
   localparam int SPR_W   = 8;
   localparam int SPR_H   = 8;
   localparam int ID_W    = 6;
   localparam int AW      = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 clear;
   logic [ID_W-1:0]      sprite_id_in, sprite_id_out;
   logic                 cfg_valid, cfg_valid_out;
   logic [ID_W-1:0]      cfg_id, cfg_id_out;
   logic [1:0]           cfg_op, cfg_op_out;
   logic [AW-1:0]        cfg_addr, cfg_addr_out;
   logic [2*COORD_W-1:0] cfg_data, cfg_data_out;
   logic                 pix_valid_in, pix_valid_out;
   logic [COORD_W-1:0]   screen_x_in, screen_y_in, screen_x_out, screen_y_out;
   logic [PIX_W-1:0]     rgb_in, rgb_out;
   logic                 hit_in, hit_out, coll_in, coll_out, coll_status;

   sprite_layer_engine dut (
      .clk(clk), .clear(clear),
      .sprite_id_in(sprite_id_in), .sprite_id_out(sprite_id_out),
      .cfg_valid(cfg_valid), .cfg_id(cfg_id), .cfg_op(cfg_op),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_valid_out(cfg_valid_out), .cfg_id_out(cfg_id_out), .cfg_op_out(cfg_op_out),
      .cfg_addr_out(cfg_addr_out), .cfg_data_out(cfg_data_out),
      .pix_valid_in(pix_valid_in), .screen_x_in(screen_x_in), .screen_y_in(screen_y_in),
      .rgb_in(rgb_in), .hit_in(hit_in), .coll_in(coll_in),
      .pix_valid_out(pix_valid_out), .screen_x_out(screen_x_out), .screen_y_out(screen_y_out),
      .rgb_out(rgb_out), .hit_out(hit_out), .coll_out(coll_out), .coll_status(coll_status)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic cfg(input logic [ID_W-1:0] id, input logic [1:0] op,
                      input logic [AW-1:0] a, input logic [15:0] d);
      cfg_valid = 1'b1; cfg_id = id; cfg_op = op; cfg_addr = a; cfg_data = d;
      step();
      cfg_valid = 1'b0;
   endtask

   // Present one pixel for one edge, then wait the second edge so its result is on the outputs.
   task automatic pix(input int x, input int y, input logic [7:0] rgb, input logic h, input logic c);
      pix_valid_in = 1'b1; screen_x_in = 8'(x); screen_y_in = 8'(y);
      rgb_in = rgb; hit_in = h; coll_in = c;
      step();
      pix_valid_in = 1'b0; hit_in = 1'b0; coll_in = 1'b0;
      step();
   endtask

   task automatic check_pix(input string name, input int x, input int y, input logic [7:0] rgb,
                            input logic h, input logic c,
                            input logic [7:0] ergb, input logic eh, input logic ec);
      pix(x, y, rgb, h, c);
      check({name, ".valid"}, pix_valid_out, 1);
      check({name, ".x"}, screen_x_out, x[7:0]);
      check({name, ".rgb"}, rgb_out, ergb);
      check({name, ".hit"}, hit_out, eh);
      check({name, ".coll"}, coll_out, ec);
   endtask

   typedef struct {
      int         x, y;
      logic [7:0] rgb;
      logic       h, c;
      logic [7:0] ergb;
      logic       eh, ec;
   } vec_t;
   vec_t tbl[8];

   // Behavioural sprite model for the randomized run.
   int         mx, my;
   bit         mvis, mhf, mvf, mcoll;
   logic [7:0] mram [64];

   typedef struct {
      logic       v;
      logic [7:0] x, y, rgb;
      logic       h, c, col;
   } exp_t;

   function automatic exp_t model(input logic v, input int sx, input int sy,
                                  input logic [7:0] rgb, input logic h, input logic c);
      exp_t e;
      int rx, ry;
      logic [7:0] d;
      bit opq;
      opq = 0;
      if (mvis && v && sx >= mx && sx < mx + SPR_W && sy >= my && sy < my + SPR_H) begin
         rx = sx - mx;
         ry = sy - my;
         if (mhf) rx = SPR_W - 1 - rx;
         if (mvf) ry = SPR_H - 1 - ry;
         d = mram[ry * SPR_W + rx];
         opq = (d != 8'h00);
      end else begin
         d = 8'h00;
      end
      e.v = v; e.x = 8'(sx); e.y = 8'(sy);
      e.rgb = opq ? d : rgb;
      e.h = h | opq;
      e.c = c | (opq && h);
      e.col = opq && h;
      return e;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   exp_t ecur, eprev;
   logic       rv, rh, rc, rcfg;
   int         rsx, rsy;
   logic [7:0] rrgb;
   logic [ID_W-1:0] rid;
   logic [1:0] rop;
   logic [AW-1:0] raddr;
   logic [15:0] rdat;

   initial begin
      clear = 1'b0; sprite_id_in = 6'd3;
      cfg_valid = 1'b0; cfg_id = '0; cfg_op = '0; cfg_addr = '0; cfg_data = '0;
      pix_valid_in = 1'b0; screen_x_in = '0; screen_y_in = '0; rgb_in = '0;
      hit_in = 1'b0; coll_in = 1'b0;

      do_clear();
      check("rst.valid", pix_valid_out, 0);
      check("rst.rgb", rgb_out, 0);
      check("rst.hit", hit_out, 0);
      check("rst.coll_status", coll_status, 0);

      // Combinational id increment and config pass-through
      sprite_id_in = 6'd63; #1;
      check("id.wrap", sprite_id_out, 0);
      sprite_id_in = 6'd3; #1;
      check("id.inc", sprite_id_out, 4);
      cfg_valid = 1'b1; cfg_id = 6'd9; cfg_op = 2'b11; cfg_addr = 6'd45; cfg_data = 16'hBEEF; #1;
      check("pass.valid", cfg_valid_out, 1);
      check("pass.id", cfg_id_out, 9);
      check("pass.op", cfg_op_out, 3);
      check("pass.addr", cfg_addr_out, 45);
      check("pass.data", cfg_data_out, 16'hBEEF);
      cfg_valid = 1'b0;
      step();

      // Basic setup: sprite 3 at (10,20), visible, pattern 0x5A except index 0 transparent
      cfg(6'd3, 2'b00, 6'd0, 16'h140A);
      cfg(6'd3, 2'b01, 6'd0, 16'h0001);
      for (int i = 0; i < 64; i++) cfg(6'd3, 2'b10, 6'(i), (i == 0) ? 16'h0000 : 16'h005A);

      tbl[0] = '{11, 20, 8'h22, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
      tbl[1] = '{10, 20, 8'h22, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0};
      tbl[2] = '{ 9, 20, 8'h22, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0};
      tbl[3] = '{17, 27, 8'h31, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0};
      tbl[4] = '{18, 20, 8'h31, 1'b0, 1'b0, 8'h31, 1'b0, 1'b0};
      tbl[5] = '{12, 28, 8'h40, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0};
      tbl[6] = '{10, 20, 8'h44, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0};
      tbl[7] = '{30, 30, 8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++)
         check_pix($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].rgb, tbl[i].h, tbl[i].c,
                   tbl[i].ergb, tbl[i].eh, tbl[i].ec);
      check("tbl.coll_status", coll_status, 0);

      // Writes addressed to another id leave this sprite untouched
      do_clear();
      cfg(6'd4, 2'b00, 6'd0, 16'h140A);
      cfg(6'd4, 2'b01, 6'd0, 16'h0001);
      check_pix("otherid", 11, 20, 8'h22, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0);

      // Clipping at the right screen edge
      cfg(6'd3, 2'b00, 6'd0, 16'h00FC);
      cfg(6'd3, 2'b01, 6'd0, 16'h0001);
      check_pix("clip.nowrap", 2, 0, 8'h22, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0);
      check_pix("clip.edge", 255, 0, 8'h22, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0);
      cfg(6'd3, 2'b01, 6'd0, 16'h0000);
      check_pix("clip.invis", 255, 0, 8'h22, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0);

      // Flips
      cfg(6'd3, 2'b10, 6'd7, 16'h0011);
      cfg(6'd3, 2'b00, 6'd0, 16'h0000);
      cfg(6'd3, 2'b01, 6'd0, 16'h0003);
      check_pix("hflip", 0, 0, 8'h22, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0);
      cfg(6'd3, 2'b10, 6'd63, 16'h0033);
      cfg(6'd3, 2'b01, 6'd0, 16'h0007);
      check_pix("hvflip.0", 0, 0, 8'h22, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0);
      check_pix("hvflip.7", 7, 0, 8'h22, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0);
      cfg(6'd3, 2'b01, 6'd0, 16'h0005);
      check_pix("vflip.7", 7, 0, 8'h22, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0);
      check_pix("vflip.tr", 0, 7, 8'h22, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0);

      // Collisions and sticky status
      cfg(6'd3, 2'b01, 6'd0, 16'h0001);
      check_pix("coll.set", 1, 1, 8'h22, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1);
      check("coll.status1", coll_status, 1);
      check_pix("coll.nohit", 3, 3, 8'h22, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0);
      check_pix("coll.transp", 0, 0, 8'h66, 1'b1, 1'b0, 8'h66, 1'b1, 1'b0);
      check("coll.sticky", coll_status, 1);
      cfg(6'd3, 2'b01, 6'd0, 16'h0009);
      check("coll.cleared", coll_status, 0);

      // Clear-collision write on the same edge as a collision wins
      pix_valid_in = 1'b1; screen_x_in = 8'd1; screen_y_in = 8'd1; rgb_in = 8'h22; hit_in = 1'b1; coll_in = 1'b0;
      step();
      pix_valid_in = 1'b0; hit_in = 1'b0;
      cfg_valid = 1'b1; cfg_id = 6'd3; cfg_op = 2'b01; cfg_addr = '0; cfg_data = 16'h0009;
      step();
      cfg_valid = 1'b0;
      check("race.coll_out", coll_out, 1);
      check("race.coll_status", coll_status, 0);

      // Read and write of the same pattern entry on one edge: old data is read
      pix_valid_in = 1'b1; screen_x_in = 8'd2; screen_y_in = 8'd1; rgb_in = 8'h22;
      cfg_valid = 1'b1; cfg_id = 6'd3; cfg_op = 2'b10; cfg_addr = 6'd10; cfg_data = 16'h0077;
      step();
      pix_valid_in = 1'b0; cfg_valid = 1'b0;
      step();
      check("rdw.old", rgb_out, 8'h5A);
      check_pix("rdw.new", 2, 1, 8'h22, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0);

      // Clear with pixels in flight and a config write on the clear edge
      pix_valid_in = 1'b1; screen_x_in = 8'd1; screen_y_in = 8'd1; rgb_in = 8'h22;
      step();
      screen_x_in = 8'd2; screen_y_in = 8'd2;
      step();
      screen_x_in = 8'd3; screen_y_in = 8'd3; clear = 1'b1;
      cfg_valid = 1'b1; cfg_id = 6'd3; cfg_op = 2'b01; cfg_data = 16'h0001;
      step();
      clear = 1'b0; cfg_valid = 1'b0; pix_valid_in = 1'b0;
      check("clr.valid0", pix_valid_out, 0);
      check("clr.rgb0", rgb_out, 0);
      check("clr.x0", screen_x_out, 0);
      check("clr.hit0", hit_out, 0);
      step();
      check("clr.valid1", pix_valid_out, 0);
      check_pix("clr.invis", 1, 1, 8'h22, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0);
      cfg(6'd3, 2'b01, 6'd0, 16'h0001);
      check_pix("clr.vis", 1, 1, 8'h22, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0);

      // Randomized run against the model
      do_clear();
      mx = 0; my = 0; mvis = 0; mhf = 0; mvf = 0; mcoll = 0;
      for (int i = 0; i < 64; i++) begin
         rdat = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 255));
         mram[i] = rdat[7:0];
         cfg(6'd3, 2'b10, 6'(i), rdat);
      end
      cfg(6'd3, 2'b00, 6'd0, 16'h3028); mx = 40; my = 48;
      cfg(6'd3, 2'b01, 6'd0, 16'h0001); mvis = 1;
      eprev = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
      for (int k = 0; k < 400; k++) begin
         rv   = ($urandom_range(0, 3) != 0);
         rsx  = (mx + $urandom_range(0, 11) + 254) % 256;
         rsy  = (my + $urandom_range(0, 11) + 254) % 256;
         rrgb = 8'($urandom_range(0, 255));
         rh   = ($urandom_range(0, 2) == 0);
         rc   = ($urandom_range(0, 3) == 0);
         rcfg = ($urandom_range(0, 5) == 0);
         rid  = ($urandom_range(0, 1) == 0) ? 6'd3 : 6'd5;
         rop  = 2'($urandom_range(0, 3));
         raddr = 6'($urandom_range(0, 63));
         rdat = 16'($urandom_range(0, 65535));
         if (rop == 2'b01) rdat = {12'h000, 1'($urandom_range(0, 7) == 0), rdat[2:1], 1'($urandom_range(0, 4) != 0)};
         if (rop == 2'b10 && $urandom_range(0, 3) == 0) rdat = 16'h0000;

         pix_valid_in = rv; screen_x_in = 8'(rsx); screen_y_in = 8'(rsy);
         rgb_in = rrgb; hit_in = rh; coll_in = rc;
         cfg_valid = rcfg; cfg_id = rid; cfg_op = rop; cfg_addr = raddr; cfg_data = rdat;

         ecur = model(rv, rsx, rsy, rrgb, rh, rc);
         if (eprev.col) mcoll = 1;
         if (rcfg && rid == 6'd3) begin
            case (rop)
               2'b00: begin mx = int'(rdat[7:0]); my = int'(rdat[15:8]); end
               2'b01: begin
                  mvis = rdat[0]; mhf = rdat[1]; mvf = rdat[2];
                  if (rdat[3]) mcoll = 0;
               end
               2'b10: mram[raddr] = rdat[7:0];
               default: ;
            endcase
         end
         step();
         if (k > 0) begin
            check("rnd.valid", pix_valid_out, eprev.v);
            check("rnd.x", screen_x_out, eprev.x);
            check("rnd.y", screen_y_out, eprev.y);
            check("rnd.rgb", rgb_out, eprev.rgb);
            check("rnd.hit", hit_out, eprev.h);
            check("rnd.coll", coll_out, eprev.c);
            check("rnd.coll_status", coll_status, mcoll);
         end
         eprev = ecur;
      end
      cfg_valid = 1'b0; pix_valid_in = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
